// File: rtl/uart_rx_sipo.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, 8N1 frame to a valid/ready byte.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_sipo #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sr;
  logic          rx_meta, rx_s, rx_prev;
  logic          complete;

  // rx_prev lets IDLE react only to a genuine 1->0 transition of the synchronised line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign complete = (state == STOP) && (cnt == BIT_LAST) && rx_s && !par_bad;
`else
  assign complete = (state == STOP) && (cnt == BIT_LAST) && rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sr         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif

      // A completion coinciding with an accept reloads without dropping data_valid
      if (complete) begin
        if (!data_valid || data_ready) begin
          data_out   <= sr;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            sr  <= {rx_s, sr[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            par_bad    <= ^{sr, rx_s};
            parity_err <= ^{sr, rx_s};
            state      <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Randomised bench for uart_rx_sipo: frame outcomes are scheduled by cycle from the line format,
// and a handshake model predicts data_valid/data_out/pulses every cycle.
module tb_uart_rx_sipo;
  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_sipo #(.CLKS_PER_BIT(N)) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rise = 0;
  logic dv_prev = 1'b0;
  logic rnd_ready = 1'b0;

  // Outcomes indexed by the cycle in which the effect becomes visible
  logic [7:0] done_at [int];
  logic       ferr_at [int];
  logic       perr_at [int];

  logic [7:0] md = 8'h00;
  logic       mv = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       exp_perr = 1'b0;
  logic       exp_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Handshake model, evaluated with the inputs the DUT sees at this edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    exp_ovr  = 1'b0;
    if (rst) begin
      mv = 1'b0;
      md = 8'h00;
      done_at.delete();
      ferr_at.delete();
      perr_at.delete();
    end else begin
      exp_ferr = ferr_at.exists(cyc);
      exp_perr = perr_at.exists(cyc);
      if (done_at.exists(cyc)) begin
        if (!mv || data_ready) begin
          md = done_at[cyc];
          mv = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (mv && data_ready) begin
        mv = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("data_valid", {31'd0, data_valid}, {31'd0, mv});
    check("data_out", {24'd0, data_out}, {24'd0, md});
    check("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
    check("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
`ifdef UART_RX_PARITY_EN
    check("parity_err", {31'd0, parity_err}, {31'd0, exp_perr});
`endif
    if (data_valid && !dv_prev) last_rise = cyc;
    dv_prev = data_valid;
  end

  task automatic drive_bit(input logic v, input int n);
    rx_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; rx_in falls in cycle k, so the FSM sees the edge in cycle k+2 (t0)
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int rst_bit);
    int k;
    int t_stop;
    logic par_ok;
    k = cyc;
    t_stop = k + 2 + H + (9 + PB) * N + 1;
    par_ok = (PB == 0) || (^{d, par} == 1'b0);
    if (PB != 0 && !par_ok) perr_at[k + 2 + H + 9 * N + 1] = 1'b1;
    if (!stop) ferr_at[t_stop] = 1'b1;
    else if (par_ok) done_at[t_stop] = d;
    drive_bit(1'b0, N);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        rst = 1'b1;
        drive_bit(d[i], 2);
        rst = 1'b0;
        drive_bit(d[i], N - 2);
      end else begin
        drive_bit(d[i], N);
      end
    end
    if (PB != 0) drive_bit(par, N);
    drive_bit(stop, N);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) data_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int k_a5;
    logic [7:0] d;
    logic stop;
    logic par;
    rst = 1'b1;
    rx_in = 1'b1;
    data_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_bit(1'b1, 10);

    // Basic frame, consumer always ready
    k_a5 = cyc;
    send_frame(8'hA5, 1'b1, ^8'hA5, -1);
    drive_bit(1'b1, 20);
    check("a5_rise_cycle", last_rise, k_a5 + 2 + 153 + PB * N);

    // Short low glitch on idle line
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 30);

    // Bad stop bit, then break, then a good frame
    send_frame(8'h3C, 1'b0, ^8'h3C, -1);
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 20);
    send_frame(8'h81, 1'b1, ^8'h81, -1);
    drive_bit(1'b1, 20);

    // Overrun with consumer stalled
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, ^8'h11, -1);
    send_frame(8'h22, 1'b1, ^8'h22, -1);
    drive_bit(1'b1, 20);
    data_ready = 1'b1;
    drive_bit(1'b1, 5);

    // Reset in the middle of a frame, then recover
    send_frame(8'hFF, 1'b1, ^8'hFF, 4);
    drive_bit(1'b1, 20);
    send_frame(8'h5A, 1'b1, ^8'h5A, -1);
    drive_bit(1'b1, 20);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1);
    drive_bit(1'b1, 20);
    send_frame(8'h07, 1'b1, 1'b0, -1);
    drive_bit(1'b1, 20);
`endif

    // Random frames, random gaps (including back-to-back) and random consumer stalls
    rnd_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      par = (^d) ^ ($urandom_range(0, 5) == 0);
      send_frame(d, stop, par, -1);
      if (!stop) drive_bit(1'b1, 4 + $urandom_range(0, 10));
      else if ($urandom_range(0, 2) != 0) drive_bit(1'b1, $urandom_range(1, 12));
    end
    rnd_ready = 1'b0;
    #2;
    data_ready = 1'b1;
    drive_bit(1'b1, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_sipo.md
# uart_rx_sipo

Serial-in/parallel-out UART receiver: the receive-side counterpart of the transmit path's parallel-in/serial-out register. It synchronises the asynchronous `rx_in` line, detects the start bit and samples each bit at mid-bit. It assembles an 8-bit LSB-first frame, checks the stop bit, and presents the byte on a valid/ready handshake to the consumer (FIFO or control FSM). It sits between the UART pad and the receive datapath, using the same line format as the transmitter: 1 start, 8 data, optional parity, 1 stop.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per bit period (100 MHz / 115200). Must be ≥ 4.
- `clk` in 1: global clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `rx_in` in 1: asynchronous serial line, idle high.
- `data_out` out 8: received byte, valid while `data_valid` is high.
- `data_valid` out 1: byte available, held until accepted.
- `data_ready` in 1: consumer accepts the byte when `data_valid && data_ready`.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a completed byte is dropped.
- `parity_err` out 1: one-cycle pulse on parity mismatch. Present only with the macro in Configuration.

## Operation
- `rx_in` passes through a 2-flop synchroniser (`rx_s`), with both flops reset to 1. All logic uses `rx_s`.
- The bit counter is `ceil(log2(CLKS_PER_BIT))` bits wide. `H = CLKS_PER_BIT/2`, integer floor.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
  - IDLE: a transition of `rx_s` from 1 to 0 → START, counter cleared. This cycle is t0.
  - START: at t0+H, sample `rx_s`. If 0 → DATA with bit index 0. If 1 (glitch) → IDLE with no output and no error.
  - DATA: sample at t0+H+k·N for k = 1..8, where N = `CLKS_PER_BIT`. Each sample shifts in at the MSB of the shift register and shifts right, so bit 0 ends in `sr[0]`. After k = 8 → PARITY if compiled in, else STOP.
  - STOP: sample at t0+H+9·N, or t0+H+10·N with parity.
    - If 1: the byte completes → IDLE.
    - If 0: pulse `frame_err`, discard the byte → WAIT_IDLE.
  - WAIT_IDLE: remain until `rx_s` = 1, then → IDLE. A break (line held low) never re-triggers START.
- Output holding register:
  - On byte completion with `data_valid` = 0: load `data_out` and set `data_valid`.
  - On completion while `data_valid` = 1 and `data_ready` = 0: keep the old byte and pulse `overrun`.
  - On completion in the same cycle as an accept: load the new byte, keep `data_valid` = 1, no overrun.
  - On an accept with no completion: clear `data_valid` next cycle.
- `data_out` changes only on load.

## Timing
- Reset values: `data_out` = 8'h00, `data_valid` = 0, `frame_err` = 0, `overrun` = 0, `parity_err` = 0, FSM = IDLE, synchroniser = 1.
- Reset asserted mid-frame aborts the frame and drops any pending byte. The first edge after reset is detected only after `rx_s` has been seen high.
- Latency: `data_valid` rises at cycle t0+H+9·N+1, or t0+H+10·N+1 with parity. t0 is 2 cycles after the falling edge reaches `rx_in`, due to the synchroniser.
- Error pulses are registered and aligned to the cycle after the failing sample.
- A new start bit may be detected in the cycle after STOP returns to IDLE. Back-to-back frames are supported, tolerating ±(H−1)/N drift.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: a PARITY state samples at t0+H+9·N and expects even parity over data bits plus the parity bit.
  - On mismatch: pulse `parity_err`, still check the stop bit, and discard the byte.
  - Undefined: no PARITY state, `parity_err` port absent, stop bit at t0+H+9·N.

## Test plan
- Bench uses `CLKS_PER_BIT` = 16.
- Send 8'hA5 with a correct stop bit, `data_ready` held 1 → `data_out` = 8'hA5, `data_valid` high exactly 1 cycle, at t0+153.
- Send a 5-cycle low glitch on an idle line → no `data_valid`, no `frame_err`, FSM back to IDLE.
- Send 8'h3C with the stop bit forced 0, then hold the line low for 40 cycles, then 8'h81 → one `frame_err` pulse, no output for 8'h3C, then `data_out` = 8'h81.
- `data_ready` = 0, send 8'h11 then 8'h22 → `data_valid` held with 8'h11, one `overrun` pulse at completion of 8'h22, `data_out` still 8'h11.
- Assert `rst` at data bit 4 of 8'hFF → all outputs at reset values; a following 8'h5A is received correctly.
- With `UART_RX_PARITY_EN`: 8'h07 with parity bit 1 → accepted. With parity bit 0 → `parity_err` pulse, no `data_valid`.
